// File: rtl/floor_request_latch.sv
// Floor call latch for a four-floor car: synchronises and debounces the raw
// call buttons, latches pending calls until served, and runs an up/down scan
// that picks the floor the motion logic should head for next.
module floor_request_latch #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] cur_floor,
    input  logic       served,
    output logic [3:0] req,
    output logic       req_valid,
    output logic [1:0] target,
    output logic [1:0] dir
);

    // The encoding doubles as the dir output value.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } scan_state_t;

    // Counter value on which the next differing cycle completes the debounce.
    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  rise;
    logic [3:0]  clr_mask;
    logic [3:0]  req_q;
    logic [3:0]  req_d;
    logic        req_valid_q;
    scan_state_t state_q;
    logic [1:0]  target_q;

    logic        above_any;
    logic        below_any;
    logic [1:0]  low_above;
    logic [1:0]  high_below;
    logic [1:0]  dist_above;
    logic [1:0]  dist_below;

    // Two-flop synchroniser on every raw button bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_db
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic       db_q;
            logic       db_d;

            // Count consecutive cycles of disagreement; flip the level once enough accumulate.
            always_comb begin
                cnt_d = '0;
                db_d  = db_q;
                if (sync2_q[gi] != db_q) begin
                    if (cnt_q == CNT_LAST) begin
                        db_d = ~db_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            // Debounce state for this button.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            // A new press is signalled on the very edge the debounced level rises.
            assign rise[gi] = db_d & ~db_q;
        end
    endgenerate

    // Latch new presses and drop the served floor; a clear beats a set on the same bit.
    always_comb begin
        clr_mask = served ? (4'b0001 << cur_floor) : 4'b0000;
        req_d    = (req_q | rise) & ~clr_mask;
    end

    // Pending-call register with its summary flag updated alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
        end else begin
            req_q       <= req_d;
            req_valid_q <= |req_d;
        end
    end

    // Nearest pending call above and below the car, from the registered calls.
    always_comb begin
        above_any  = 1'b0;
        below_any  = 1'b0;
        low_above  = cur_floor;
        high_below = cur_floor;
        for (int f = 3; f >= 0; f--) begin
            if (f > int'(cur_floor) && req_q[f]) begin
                above_any = 1'b1;
                low_above = 2'(f);
            end
        end
        for (int f = 0; f < 4; f++) begin
            if (f < int'(cur_floor) && req_q[f]) begin
                below_any  = 1'b1;
                high_below = 2'(f);
            end
        end
        dist_above = low_above - cur_floor;
        dist_below = cur_floor - high_below;
    end

    // Scan FSM: keep going in the current direction while calls remain ahead, else reverse or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= 2'b00;
        end else if (req_q[cur_floor]) begin
            target_q <= cur_floor;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (above_any && below_any) begin
                        if (dist_above <= dist_below) begin
                            state_q  <= S_UP;
                            target_q <= low_above;
                        end else begin
                            state_q  <= S_DOWN;
                            target_q <= high_below;
                        end
                    end else if (above_any) begin
                        state_q  <= S_UP;
                        target_q <= low_above;
                    end else if (below_any) begin
                        state_q  <= S_DOWN;
                        target_q <= high_below;
                    end else begin
                        target_q <= cur_floor;
                    end
                end
                S_UP: begin
                    if (above_any) begin
                        target_q <= low_above;
                    end else if (below_any) begin
                        state_q  <= S_DOWN;
                        target_q <= high_below;
                    end else begin
                        state_q  <= S_IDLE;
                        target_q <= cur_floor;
                    end
                end
                S_DOWN: begin
                    if (below_any) begin
                        target_q <= high_below;
                    end else if (above_any) begin
                        state_q  <= S_UP;
                        target_q <= low_above;
                    end else begin
                        state_q  <= S_IDLE;
                        target_q <= cur_floor;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    target_q <= cur_floor;
                end
            endcase
        end
    end

    assign req       = req_q;
    assign req_valid = req_valid_q;
    assign target    = target_q;
    assign dir       = state_q;

endmodule
